// File: rtl/alu_fifo_pkg.sv
// Shared ALU opcode encoding and default sizing for the ALU result FIFO.
package alu_fifo_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: modulo-2^WIDTH arithmetic/logic, no carry or borrow out.
module alu_core
  import alu_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] result_o
);

  alu_op_e op_e;
  assign op_e = alu_op_e'(op_i);

  always_comb begin
    result_o = '0;
    case (op_e)
      OP_ADD: result_o = a_i + b_i;
      OP_SUB: result_o = a_i - b_i;
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_NOT: result_o = ~a_i;
      OP_SHL: result_o = {a_i[WIDTH-2:0], 1'b0};
      OP_SHR: result_o = {1'b0, a_i[WIDTH-1:1]};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_result_fifo.sv
// ALU whose combinational result can be pushed into a synchronous FIFO with
// registered read data.
module alu_result_fifo
  import alu_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             do_wr, do_rd;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a_i      (A),
    .b_i      (B),
    .op_i     (op),
    .result_o (result)
  );

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign data_out = dout_q;

  // A read on a full FIFO frees a slot on the same edge, so the write is also taken.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;
    if (do_wr) wptr_d = wptr_q + PTR_W'(1);
    if (do_rd) begin
      rptr_d = rptr_q + PTR_W'(1);
      dout_d = mem_q[rptr_q];
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  // Storage is not reset; the cleared pointers and count make old words unreachable.
  always_ff @(posedge clk) begin
    if (!reset && do_wr) mem_q[wptr_q] <= result;
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: ALU vector table, directed FIFO
// corner sequences and a randomized run against a queue-based reference model.
module tb_alu_result_fifo;
  import alu_fifo_pkg::*;

  localparam int W = 8;
  localparam int D = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] A, B;
  logic [2:0]   op;
  logic [W-1:0] result;
  logic         wr_en, rd_en;
  logic [W-1:0] data_out;
  logic         full, empty;

  alu_result_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .op       (op),
    .result   (result),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  // Scoreboard state: expected FIFO contents and expected data_out.
  int unsigned sb_q[$];
  int unsigned sb_dout;

  function automatic int unsigned ref_alu(int unsigned a, int unsigned b, int unsigned o);
    int unsigned r;
    case (o)
      0: r = a + b + 256;
      1: r = a + 256 - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: r = a * 2;
      default: r = a / 2;
    endcase
    return r % 256;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [7:0] v);
    A = v; B = 8'h00; op = OP_OR; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk(name, data_out, exp);
  endtask

  initial begin
    reset = 1'b0; A = '0; B = '0; op = '0; wr_en = 1'b0; rd_en = 1'b0;

    vecs[0]  = '{8'h01, 8'h01, OP_ADD, 8'h02};
    vecs[1]  = '{8'h02, 8'h01, OP_SUB, 8'h01};
    vecs[2]  = '{8'hFF, 8'h0F, OP_AND, 8'h0F};
    vecs[3]  = '{8'hA0, 8'h05, OP_OR,  8'hA5};
    vecs[4]  = '{8'hFF, 8'h0F, OP_XOR, 8'hF0};
    vecs[5]  = '{8'h0F, 8'hAA, OP_NOT, 8'hF0};
    vecs[6]  = '{8'h81, 8'h00, OP_SHL, 8'h02};
    vecs[7]  = '{8'h81, 8'h00, OP_SHR, 8'h40};
    vecs[8]  = '{8'hFF, 8'h02, OP_ADD, 8'h01};
    vecs[9]  = '{8'h00, 8'h01, OP_SUB, 8'hFF};
    vecs[10] = '{8'h01, 8'h33, OP_SHR, 8'h00};
    vecs[11] = '{8'hF0, 8'h3C, OP_XOR, 8'hCC};

    // Reset state
    do_reset();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_dout", data_out, 0);

    // ALU vector table (combinational, no clock needed)
    for (int i = 0; i < 12; i++) begin
      A = vecs[i].a; B = vecs[i].b; op = vecs[i].op;
      #1;
      chk($sformatf("alu_vec%0d", i), result, vecs[i].exp);
    end

    // Basic push/pop sequence
    for (int i = 0; i < 5; i++) begin
      A = vecs[i % 3].a; B = vecs[i % 3].b; op = vecs[i % 3].op;
      if (i == 3) begin A = 8'h01; B = 8'h01; op = OP_ADD; end
      if (i == 4) begin A = 8'h02; B = 8'h01; op = OP_SUB; end
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
    end
    pop_chk("seq_pop0", 8'h02);
    pop_chk("seq_pop1", 8'h01);
    pop_chk("seq_pop2", 8'h0F);
    pop_chk("seq_pop3", 8'h02);
    pop_chk("seq_pop4", 8'h01);
    chk("seq_empty", empty, 1);

    // Fill, overflow drop, drain
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    chk("fill_full", full, 1);
    push(8'h55);
    chk("ovf_full", full, 1);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("drain%0d", i), 8'(8'h10 + i));
    chk("drain_empty", empty, 1);
    chk("drain_nfull", full, 0);

    // Full FIFO with simultaneous read and write
    for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
    A = 8'h99; B = 8'h00; op = OP_OR; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("full_rw_dout", data_out, 8'h20);
    chk("full_rw_full", full, 1);
    for (int i = 1; i < 8; i++) pop_chk($sformatf("full_rw_pop%0d", i), 8'(8'h20 + i));
    pop_chk("full_rw_new", 8'h99);
    pop_chk("empty_pop_hold", 8'h99);
    chk("empty_pop_empty", empty, 1);

    // Empty FIFO with simultaneous read and write: only the write is taken
    A = 8'h77; B = 8'h00; op = OP_OR; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("empty_rw_dout", data_out, 8'h99);
    chk("empty_rw_nempty", empty, 0);
    pop_chk("empty_rw_pop", 8'h77);

    // Pointer wrap with interleaved push/pop
    do_reset();
    push(8'h30); push(8'h31);
    for (int i = 0; i < 12; i++) begin
      push(8'(8'h40 + i));
      pop_chk($sformatf("wrap%0d", i), (i < 2) ? 8'(8'h30 + i) : 8'(8'h40 + i - 2));
    end

    // Reset mid-operation discards stored entries
    do_reset();
    push(8'hA1); push(8'hA2); push(8'hA3);
    do_reset();
    chk("midrst_empty", empty, 1);
    chk("midrst_dout", data_out, 0);
    pop_chk("midrst_pop", 8'h00);
    chk("midrst_empty2", empty, 1);

    // Reset has priority over simultaneous wr_en/rd_en
    push(8'hB1);
    A = 8'hB2; wr_en = 1'b1; rd_en = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("rstprio_empty", empty, 1);
    chk("rstprio_dout", data_out, 0);

    // Randomized run against the reference model
    sb_q.delete();
    sb_dout = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int unsigned exp_res;
      logic rst_now;
      logic rd_ok, wr_ok;
      A = 8'($urandom); B = 8'($urandom); op = 3'($urandom);
      wr_en = ($urandom_range(0, 99) < 55);
      rd_en = ($urandom_range(0, 99) < 45);
      rst_now = ($urandom_range(0, 199) == 0);
      reset = rst_now;
      exp_res = ref_alu(A, B, op);
      #1;
      chk("rnd_result", result, exp_res);
      if (rst_now) begin
        sb_q.delete();
        sb_dout = 0;
      end else begin
        rd_ok = rd_en && (sb_q.size() > 0);
        wr_ok = wr_en && ((sb_q.size() < D) || rd_ok);
        if (rd_ok) sb_dout = sb_q.pop_front();
        if (wr_ok) sb_q.push_back(exp_res);
      end
      tick();
      reset = 1'b0;
      chk("rnd_dout", data_out, sb_dout);
      chk("rnd_full", full, (sb_q.size() == D) ? 1 : 0);
      chk("rnd_empty", empty, (sb_q.size() == 0) ? 1 : 0);
    end
    wr_en = 1'b0; rd_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
